// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the multi-cycle multiply/divide unit:
//   - op code constants for the op field (MULT .. MTLO, 6-7 reserved)
//   - FSM state encoding (IDLE / RUN / WRITE)
//   - twos_mag(): two's-complement magnitude helper
// No ports (package).
// ---------------------------------------------------------------------------
package muldiv_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      WRITE = 2'd2
   } state_e;

   // Working width of twos_mag(). Callers zero-extend a WIDTH-bit value into
   // it and keep the low WIDTH bits, so any WIDTH up to MAG_W/2 is covered.
   localparam int MAG_W = 256;

   // Magnitude of a two's-complement value whose sign is passed separately
   // (neg = 0 for unsigned operations). The low bits of the result are
   // correct for any operand width because negation only carries upward.
   function automatic logic [MAG_W-1:0] twos_mag(input logic [MAG_W-1:0] x,
                                                 input logic             neg);
      return neg ? (~x + MAG_W'(1)) : x;
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// muldiv_unit_if
// Request/result bundle between the CPU datapath and muldiv_unit.
//   start, op[2:0], a, b, cancel      : CPU -> unit (master drives)
//   hi, lo, busy, stall, done,
//   div_by_zero                       : unit -> CPU (slave drives)
// ---------------------------------------------------------------------------
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cancel;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             stall;
   logic             done;
   logic             div_by_zero;

   modport master (
      output start, op, a, b, cancel,
      input  hi, lo, busy, stall, done, div_by_zero
   );

   modport slave (
      input  start, op, a, b, cancel,
      output hi, lo, busy, stall, done, div_by_zero
   );
endinterface

// File: rtl/muldiv_iter.sv
// ---------------------------------------------------------------------------
// muldiv_iter
// One combinational step of the iterative multiplier/divider, sharing a
// single (WIDTH+2)-bit adder between both modes.
//   div_mode_i : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_hi_i   : multiply partial product (upper) / divide partial remainder
//   acc_lo_i   : multiplier bits still to consume / dividend-quotient shifter
//   opnd_i     : multiplicand magnitude / divisor magnitude
//   acc_hi_o, acc_lo_o : accumulator values after this step
// ---------------------------------------------------------------------------
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             div_mode_i,
   input  logic [WIDTH-1:0] acc_hi_i,
   input  logic [WIDTH-1:0] acc_lo_i,
   input  logic [WIDTH-1:0] opnd_i,
   output logic [WIDTH-1:0] acc_hi_o,
   output logic [WIDTH-1:0] acc_lo_o
);

   logic [WIDTH:0]   x_op;
   logic [WIDTH:0]   y_op;
   logic [WIDTH+1:0] y_inv;
   logic [WIDTH+1:0] sum;
   logic             no_borrow;

   // Divide: shift the next dividend bit into the remainder and trial-subtract.
   // Multiply: add the multiplicand when the current multiplier bit is set.
   always_comb begin
      if (div_mode_i) begin
         x_op = {acc_hi_i, acc_lo_i[WIDTH-1]};
         y_op = {1'b0, opnd_i};
      end else begin
         x_op = {1'b0, acc_hi_i};
         y_op = acc_lo_i[0] ? {1'b0, opnd_i} : '0;
      end
   end

   // Subtraction as x + ~y + 1; the extra top bit is the borrow.
   assign y_inv     = {1'b0, y_op} ^ {(WIDTH+2){div_mode_i}};
   assign sum       = {1'b0, x_op} + y_inv + {{(WIDTH+1){1'b0}}, div_mode_i};
   assign no_borrow = ~sum[WIDTH+1];

   always_comb begin
      if (div_mode_i) begin
         // Restore on borrow; the quotient bit enters from the right.
         acc_hi_o = no_borrow ? sum[WIDTH-1:0] : x_op[WIDTH-1:0];
         acc_lo_o = {acc_lo_i[WIDTH-2:0], no_borrow};
      end else begin
         // Shift the (carry, sum, multiplier) chain right by one.
         acc_hi_o = sum[WIDTH:1];
         acc_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Executes MULT, MULTU, DIV, DIVU (WIDTH iterations, WIDTH+1 busy cycles),
// MTHI/MTLO (single edge) and optionally single-cycle multiplies (FAST_MUL).
// Parameters:
//   WIDTH    : operand/HI/LO width, even, >= 4, <= 128
//   FAST_MUL : 1 = combinational multiply, 0 = iterative shift-add
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   bus_if : muldiv_unit_if slave (start/op/a/b/cancel in,
//            hi/lo/busy/stall/done/div_by_zero out)
// ---------------------------------------------------------------------------
import muldiv_pkg::*;

module muldiv_unit #(
   parameter int WIDTH    = 32,
   parameter bit FAST_MUL = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   muldiv_unit_if.slave  bus_if
);

   localparam int CW = $clog2(WIDTH + 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic             is_div_q, is_div_d;
   logic             neg_q, neg_d;          // negate product / quotient
   logic             neg_rem_q, neg_rem_d;  // negate remainder (dividend < 0)
   logic             dz_q, dz_d;            // divisor was zero
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;

   // ---------------- request decode ----------------
   logic op_mul, op_div, op_signed, accept;
   logic a_neg, b_neg;

   assign op_mul    = (bus_if.op == OP_MULT) || (bus_if.op == OP_MULTU);
   assign op_div    = (bus_if.op == OP_DIV)  || (bus_if.op == OP_DIVU);
   assign op_signed = (bus_if.op == OP_MULT) || (bus_if.op == OP_DIV);
   assign a_neg     = op_signed & bus_if.a[WIDTH-1];
   assign b_neg     = op_signed & bus_if.b[WIDTH-1];
   // cancel wins over a simultaneous start
   assign accept    = bus_if.start & ~bus_if.cancel;

   logic [MAG_W-1:0] a_mag_ext, b_mag_ext;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             unused_mag_bits;

   assign a_mag_ext       = twos_mag(MAG_W'(bus_if.a), a_neg);
   assign b_mag_ext       = twos_mag(MAG_W'(bus_if.b), b_neg);
   assign a_mag           = a_mag_ext[WIDTH-1:0];
   assign b_mag           = b_mag_ext[WIDTH-1:0];
   assign unused_mag_bits = ^{a_mag_ext[MAG_W-1:WIDTH], b_mag_ext[MAG_W-1:WIDTH]};

   // ---------------- optional single-cycle multiplier ----------------
   logic [2*WIDTH-1:0] fast_prod;

   generate
      if (FAST_MUL) begin : g_fast_mul
         logic [2*WIDTH-1:0] mag_prod;
         assign mag_prod  = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
         assign fast_prod = (a_neg ^ b_neg) ? (~mag_prod + (2*WIDTH)'(1)) : mag_prod;
      end else begin : g_iter_mul
         assign fast_prod = '0;
      end
   endgenerate

   // ---------------- shared iteration datapath ----------------
   logic [WIDTH-1:0] iter_hi, iter_lo;

   muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_iter (
      .div_mode_i (is_div_q),
      .acc_hi_i   (acc_hi_q),
      .acc_lo_i   (acc_lo_q),
      .opnd_i     (opnd_q),
      .acc_hi_o   (iter_hi),
      .acc_lo_o   (iter_lo)
   );

   // ---------------- result sign correction ----------------
   logic [2*WIDTH-1:0] prod_raw, prod_res;
   logic [WIDTH-1:0]   quo_res, rem_res;

   assign prod_raw = {acc_hi_q, acc_lo_q};
   assign prod_res = neg_q ? (~prod_raw + (2*WIDTH)'(1)) : prod_raw;
   assign quo_res  = neg_q ? (~acc_lo_q + WIDTH'(1)) : acc_lo_q;
   assign rem_res  = neg_rem_q ? (~acc_hi_q + WIDTH'(1)) : acc_hi_q;

   // ---------------- next-state / control ----------------
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      opnd_d    = opnd_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      done_d    = 1'b0;
      dbz_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (op_mul && FAST_MUL) begin
                  hi_d   = fast_prod[2*WIDTH-1:WIDTH];
                  lo_d   = fast_prod[WIDTH-1:0];
                  done_d = 1'b1;
               end else if (op_mul || op_div) begin
                  // Multiply: multiplier |b| is shifted out of acc_lo.
                  // Divide: dividend |a| is shifted out of acc_lo while the
                  // quotient is shifted in behind it.
                  acc_hi_d  = '0;
                  acc_lo_d  = op_div ? a_mag : b_mag;
                  opnd_d    = op_div ? b_mag : a_mag;
                  is_div_d  = op_div;
                  neg_d     = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  dz_d      = op_div && (bus_if.b == '0);
                  count_d   = CW'(WIDTH);
                  state_d   = RUN;
               end else if (bus_if.op == OP_MTHI) begin
                  hi_d = bus_if.a;
               end else if (bus_if.op == OP_MTLO) begin
                  lo_d = bus_if.a;
               end
            end
         end

         RUN: begin
            if (bus_if.cancel) begin
               state_d = IDLE;
            end else begin
               acc_hi_d = iter_hi;
               acc_lo_d = iter_lo;
               count_d  = count_q - CW'(1);
               if (count_q == CW'(1)) begin
                  state_d = WRITE;
               end
            end
         end

         WRITE: begin
            state_d = IDLE;
            if (!bus_if.cancel) begin
               done_d = 1'b1;
               if (is_div_q) begin
                  // A zero divisor leaves the dividend in the remainder path,
                  // so HI already equals a; only LO needs forcing.
                  lo_d  = dz_q ? '1 : quo_res;
                  hi_d  = rem_res;
                  dbz_d = dz_q;
               end else begin
                  hi_d = prod_res[2*WIDTH-1:WIDTH];
                  lo_d = prod_res[WIDTH-1:0];
               end
            end
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         opnd_q    <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         opnd_q    <= opnd_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dbz_q     <= dbz_d;
      end
   end

   // ---------------- outputs ----------------
   // The start term covers the request cycle itself, before busy rises.
   assign bus_if.stall       = busy_q
                             | (bus_if.start & (state_q == IDLE)
                                & (op_div | (op_mul & ~FAST_MUL)));
   assign bus_if.hi          = hi_q;
   assign bus_if.lo          = lo_q;
   assign bus_if.busy        = busy_q;
   assign bus_if.done        = done_q;
   assign bus_if.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: an iterative instance (bus0) and a
// FAST_MUL instance (bus1) sharing clock and reset.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;

   muldiv_unit_if #(.WIDTH(W)) bus0 ();
   muldiv_unit_if #(.WIDTH(W)) bus1 ();

   muldiv_unit #(.WIDTH(W), .FAST_MUL(1'b0)) dut_slow (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus0)
   );

   muldiv_unit #(.WIDTH(W), .FAST_MUL(1'b1)) dut_fast (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus1)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } exp_t;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;
   int   txn    = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference model built from SystemVerilog integer arithmetic.
   function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t        r;
      int          sa, sb;
      logic [63:0] p;
      sa = a;
      sb = b;
      r  = '0;
      case (op)
         OP_MULT: begin
            p = longint'(sa) * longint'(sb);
            r.hi = p[63:32]; r.lo = p[31:0];
         end
         OP_MULTU: begin
            p = {32'd0, a} * {32'd0, b};
            r.hi = p[63:32]; r.lo = p[31:0];
         end
         default: begin
            if (b == 0) begin
               r.hi = a; r.lo = '1; r.dbz = 1'b1;
            end else if (op == OP_DIV) begin
               if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                  r.hi = '0; r.lo = a;
               end else begin
                  r.lo = sa / sb;
                  r.hi = sa % sb;
               end
            end else begin
               r.lo = a / b;
               r.hi = a % b;
            end
         end
      endcase
      return r;
   endfunction

   // Issue one multiply/divide on the iterative unit and check the result,
   // latency and busy length through the scoreboard.
   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
      int   busy_cnt;
      int   edges;
      exp_t got;
      @(negedge clk);
      bus0.start = 1'b1; bus0.op = op; bus0.a = a; bus0.b = b;
      #1;
      check("stall_on_start", bus0.stall, 1);
      sb_q.push_back(e);
      @(posedge clk); #1;
      bus0.start = 1'b0;
      busy_cnt = 0;
      edges    = -1;
      for (int n = 0; n <= W + 8; n++) begin
         if (n > 0) begin
            @(posedge clk); #1;
         end
         if (bus0.done) begin
            edges = n;
            break;
         end
         if (bus0.busy) busy_cnt++;
      end
      got = sb_q.pop_front();
      if (edges < 0) begin
         check("done_timeout", 0, 1);
      end else begin
         check("hi", bus0.hi, got.hi);
         check("lo", bus0.lo, got.lo);
         check("div_by_zero", bus0.div_by_zero, got.dbz);
         check("latency", edges, W + 1);
         check("busy_cycles", busy_cnt, W + 1);
         check("busy_after_done", bus0.busy, 0);
      end
      txn++;
      $display("txn %0d op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0b edges=%0d",
               txn, op, a, b, bus0.hi, bus0.lo, bus0.div_by_zero, edges);
      @(posedge clk); #1;
      check("done_pulse_width", bus0.done, 0);
   endtask

   task automatic wait_done(input int budget, output int edges);
      edges = -1;
      for (int n = 1; n <= budget; n++) begin
         @(posedge clk); #1;
         if (bus0.done) begin
            edges = n;
            break;
         end
      end
   endtask

   task automatic pulse_op0(input logic [2:0] op, input logic [W-1:0] a, input logic cancel);
      @(negedge clk);
      bus0.start = 1'b1; bus0.op = op; bus0.a = a; bus0.b = '0; bus0.cancel = cancel;
      @(posedge clk); #1;
      bus0.start = 1'b0; bus0.cancel = 1'b0;
   endtask

   initial begin
      int   edges;
      int   dones;
      exp_t e;
      logic [2:0]   rop;
      logic [W-1:0] ra, rb;

      rst = 1'b1;
      bus0.start = 1'b0; bus0.op = '0; bus0.a = '0; bus0.b = '0; bus0.cancel = 1'b0;
      bus1.start = 1'b0; bus1.op = '0; bus1.a = '0; bus1.b = '0; bus1.cancel = 1'b0;

      vecs.push_back('{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0});
      vecs.push_back('{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0});
      vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
      vecs.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0});
      vecs.push_back('{OP_DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1});
      vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1});
      vecs.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0});
      vecs.push_back('{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0});
      vecs.push_back('{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0});
      vecs.push_back('{OP_MULTU, 32'd0,        32'h00012345, 32'h00000000, 32'h00000000, 1'b0});

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_hi", bus0.hi, 0);
      check("rst_lo", bus0.lo, 0);
      check("rst_busy", bus0.busy, 0);
      check("rst_done", bus0.done, 0);
      check("rst_dbz", bus0.div_by_zero, 0);
      check("rst_stall", bus0.stall, 0);
      check("rst_fast_hi", bus1.hi, 0);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven vectors
      foreach (vecs[i]) begin
         e.hi = vecs[i].hi; e.lo = vecs[i].lo; e.dbz = vecs[i].dbz;
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, e);
      end

      // Start while busy is ignored: MULTU 3*4 with a DIVU request at cycle 5
      @(negedge clk);
      bus0.start = 1'b1; bus0.op = OP_MULTU; bus0.a = 32'd3; bus0.b = 32'd4;
      sb_q.push_back('{32'd0, 32'd12, 1'b0});
      @(posedge clk); #1;
      bus0.start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus0.start = 1'b1; bus0.op = OP_DIVU; bus0.a = 32'd100; bus0.b = 32'd7;
      #1;
      check("stall_while_busy", bus0.stall, 1);
      @(posedge clk); #1;
      bus0.start = 1'b0;
      wait_done(W + 8, edges);
      e = sb_q.pop_front();
      check("ignored_start_latency", edges, W + 1 - 5);
      check("ignored_start_hi", bus0.hi, e.hi);
      check("ignored_start_lo", bus0.lo, e.lo);
      wait_done(W + 8, edges);
      check("ignored_start_no_second_done", edges, -1);
      txn++;
      $display("txn %0d start-during-busy hi=%h lo=%h", txn, bus0.hi, bus0.lo);

      // MTHI / MTLO
      @(negedge clk);
      bus0.start = 1'b1; bus0.op = OP_MTHI; bus0.a = 32'h1234;
      #1;
      check("mthi_stall", bus0.stall, 0);
      @(posedge clk); #1;
      bus0.start = 1'b0;
      check("mthi_hi", bus0.hi, 32'h1234);
      check("mthi_done", bus0.done, 0);
      pulse_op0(OP_MTLO, 32'h5678, 1'b0);
      check("mtlo_lo", bus0.lo, 32'h5678);
      check("mtlo_hi_kept", bus0.hi, 32'h1234);
      txn++;
      $display("txn %0d mthi/mtlo hi=%h lo=%h", txn, bus0.hi, bus0.lo);

      // Cancel in RUN at cycle 10, with an ignored start at cycle 3
      @(negedge clk);
      bus0.start = 1'b1; bus0.op = OP_DIVU; bus0.a = 32'd100; bus0.b = 32'd7;
      @(posedge clk); #1;
      bus0.start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus0.start = 1'b1; bus0.op = OP_MULTU; bus0.a = 32'd9; bus0.b = 32'd9;
      @(posedge clk); #1;
      bus0.start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("busy_before_cancel", bus0.busy, 1);
      @(negedge clk);
      bus0.cancel = 1'b1;
      @(posedge clk); #1;
      bus0.cancel = 1'b0;
      check("cancel_busy", bus0.busy, 0);
      dones = 0;
      for (int n = 0; n < W + 8; n++) begin
         @(posedge clk); #1;
         if (bus0.done) dones++;
      end
      check("cancel_no_done", dones, 0);
      check("cancel_hi", bus0.hi, 32'h1234);
      check("cancel_lo", bus0.lo, 32'h5678);
      txn++;
      $display("txn %0d cancel-run hi=%h lo=%h", txn, bus0.hi, bus0.lo);

      // Cancel in WRITE (cycle W+1)
      @(negedge clk);
      bus0.start = 1'b1; bus0.op = OP_MULTU; bus0.a = 32'd2; bus0.b = 32'd3;
      @(posedge clk); #1;
      bus0.start = 1'b0;
      repeat (W) @(posedge clk);
      #1;
      check("busy_in_write", bus0.busy, 1);
      @(negedge clk);
      bus0.cancel = 1'b1;
      @(posedge clk); #1;
      bus0.cancel = 1'b0;
      check("cancel_write_done", bus0.done, 0);
      check("cancel_write_busy", bus0.busy, 0);
      check("cancel_write_hi", bus0.hi, 32'h1234);
      check("cancel_write_lo", bus0.lo, 32'h5678);
      txn++;
      $display("txn %0d cancel-write hi=%h lo=%h", txn, bus0.hi, bus0.lo);

      // Cancel in IDLE overrides start
      pulse_op0(OP_MTHI, 32'hDEAD, 1'b1);
      check("cancel_idle_mthi", bus0.hi, 32'h1234);
      @(negedge clk);
      bus0.start = 1'b1; bus0.op = OP_DIV; bus0.a = 32'd9; bus0.b = 32'd3; bus0.cancel = 1'b1;
      @(posedge clk); #1;
      bus0.start = 1'b0; bus0.cancel = 1'b0;
      check("cancel_idle_div_busy", bus0.busy, 0);
      pulse_op0(3'd6, 32'hBEEF, 1'b0);
      check("reserved_op_busy", bus0.busy, 0);
      check("reserved_op_hi", bus0.hi, 32'h1234);
      txn++;
      $display("txn %0d cancel-idle/reserved hi=%h lo=%h", txn, bus0.hi, bus0.lo);

      // Asynchronous reset mid-DIV at cycle 5
      @(negedge clk);
      bus0.start = 1'b1; bus0.op = OP_DIVU; bus0.a = 32'd100; bus0.b = 32'd7;
      @(posedge clk); #1;
      bus0.start = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_hi", bus0.hi, 0);
      check("async_rst_lo", bus0.lo, 0);
      check("async_rst_busy", bus0.busy, 0);
      check("async_rst_stall", bus0.stall, 0);
      #2;
      rst = 1'b0;
      txn++;
      $display("txn %0d async-reset hi=%h lo=%h busy=%0b", txn, bus0.hi, bus0.lo, bus0.busy);
      run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, '{32'hFFFFFFFE, 32'h00000001, 1'b0});

      // FAST_MUL instance: single-edge multiply, normal-latency divide
      @(negedge clk);
      bus1.start = 1'b1; bus1.op = OP_MULT; bus1.a = 32'd7; bus1.b = 32'hFFFFFFFE;
      #1;
      check("fast_stall", bus1.stall, 0);
      @(posedge clk); #1;
      bus1.start = 1'b0;
      check("fast_hi", bus1.hi, 32'hFFFFFFFF);
      check("fast_lo", bus1.lo, 32'hFFFFFFF2);
      check("fast_done", bus1.done, 1);
      check("fast_busy", bus1.busy, 0);
      @(posedge clk); #1;
      check("fast_done_pulse", bus1.done, 0);
      txn++;
      $display("txn %0d fast MULT hi=%h lo=%h", txn, bus1.hi, bus1.lo);
      @(negedge clk);
      bus1.start = 1'b1; bus1.op = OP_DIVU; bus1.a = 32'd100; bus1.b = 32'd7;
      #1;
      check("fast_div_stall", bus1.stall, 1);
      @(posedge clk); #1;
      bus1.start = 1'b0;
      edges = -1;
      for (int n = 1; n <= W + 8; n++) begin
         @(posedge clk); #1;
         if (bus1.done) begin
            edges = n;
            break;
         end
      end
      check("fast_div_latency", edges, W + 1);
      check("fast_div_lo", bus1.lo, 32'h0000000E);
      check("fast_div_hi", bus1.hi, 32'h00000002);
      txn++;
      $display("txn %0d fast DIVU hi=%h lo=%h", txn, bus1.hi, bus1.lo);

      // Random operations against the integer model
      for (int i = 0; i < 8; i++) begin
         rop = 3'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : 32'($urandom);
         run_op(rop, ra, rb, model(rop, ra, rb));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
